// File: rtl/cpu_defs.sv
// ============================================================================
// Module      : cpu_defs
// Description : Shared opcode/func constants, immediate kinds and the
//               immediate extension helper for the 16-bit four-register CPU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_ADD = 6'd0;
    localparam logic [5:0] FN_SUB = 6'd1;
    localparam logic [5:0] FN_AND = 6'd2;
    localparam logic [5:0] FN_ORR = 6'd3;
    localparam logic [5:0] FN_NOT = 6'd4;
    localparam logic [5:0] FN_TCP = 6'd5;
    localparam logic [5:0] FN_SHL = 6'd6;
    localparam logic [5:0] FN_SHR = 6'd7;
    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    localparam logic [1:0] LINK_REG = 2'd2;

    typedef enum logic [1:0] {
        IMM_SEXT = 2'd0,
        IMM_ZEXT = 2'd1,
        IMM_LHI  = 2'd2,
        IMM_JTGT = 2'd3
    } imm_kind_e;

    function automatic logic [15:0] ext_imm(input imm_kind_e kind, input logic [15:0] instr);
        logic [15:0] r;
        case (kind)
            IMM_ZEXT: r = {8'h00, instr[7:0]};
            IMM_LHI:  r = {instr[7:0], 8'h00};
            IMM_JTGT: r = {4'b0000, instr[11:0]};
            default:  r = {{8{instr[7]}}, instr[7:0]};
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_decoder.sv
// ============================================================================
// Module      : id_decoder
// Description : Combinational instruction decoder: source usage, destination,
//               control bits and extended immediate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_decoder
    import cpu_defs::*;
(
    input  logic [15:0] instr_i,
    output logic        use_rs_o,
    output logic        use_rt_o,
    output logic [1:0]  dest_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        halt_o,
    output logic [15:0] imm_o
);

    logic [3:0] op;
    logic [5:0] fn;
    imm_kind_e  kind;

    assign op = instr_i[15:12];
    assign fn = instr_i[5:0];

    always_comb begin
        use_rs_o    = 1'b0;
        use_rt_o    = 1'b0;
        dest_o      = 2'd0;
        reg_write_o = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        halt_o      = 1'b0;
        kind        = IMM_SEXT;
        case (op)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
                use_rs_o = 1'b1;
                use_rt_o = 1'b1;
            end
            OP_ADI: begin
                use_rs_o    = 1'b1;
                reg_write_o = 1'b1;
                dest_o      = instr_i[9:8];
            end
            OP_ORI: begin
                use_rs_o    = 1'b1;
                reg_write_o = 1'b1;
                dest_o      = instr_i[9:8];
                kind        = IMM_ZEXT;
            end
            OP_LHI: begin
                reg_write_o = 1'b1;
                dest_o      = instr_i[9:8];
                kind        = IMM_LHI;
            end
            OP_LWD: begin
                use_rs_o    = 1'b1;
                reg_write_o = 1'b1;
                mem_read_o  = 1'b1;
                dest_o      = instr_i[9:8];
            end
            OP_SWD: begin
                use_rs_o    = 1'b1;
                use_rt_o    = 1'b1;
                mem_write_o = 1'b1;
            end
            OP_JMP: kind = IMM_JTGT;
            OP_JAL: begin
                kind        = IMM_JTGT;
                reg_write_o = 1'b1;
                dest_o      = LINK_REG;
            end
            OP_RTYPE: begin
                use_rs_o = 1'b1;
                // ALU ops 0-3 are binary; 4-7 use rs only
                use_rt_o = (fn <= FN_ORR);
                if (fn <= FN_SHR) begin
                    reg_write_o = 1'b1;
                    dest_o      = instr_i[7:6];
                end else if (fn == FN_JRL) begin
                    reg_write_o = 1'b1;
                    dest_o      = LINK_REG;
                end
                halt_o = (fn == FN_HLT);
            end
            default: ;
        endcase
    end

    assign imm_o = ext_imm(kind, instr_i);

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
// Module      : id_stage
// Description : Decode stage: IF/ID and ID/EX pipeline registers, write-back
//               bypass of register operands and load-use hazard stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_valid,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc,
    output logic        stall,
    input  logic        flush,
    output logic [1:0]  rf_read1,
    output logic [1:0]  rf_read2,
    input  logic [15:0] rf_out1,
    input  logic [15:0] rf_out2,
    input  logic        wb_reg_write,
    input  logic [1:0]  wb_dest,
    input  logic [15:0] wb_data,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic [1:0]  ex_dest,
    output logic        idex_valid,
    output logic [15:0] idex_pc,
    output logic [3:0]  idex_opcode,
    output logic [5:0]  idex_func,
    output logic [15:0] idex_a,
    output logic [15:0] idex_b,
    output logic [15:0] idex_imm,
    output logic [1:0]  idex_dest,
    output logic        idex_reg_write,
    output logic        idex_mem_read,
    output logic        idex_mem_write,
    output logic        idex_halt
);

    logic        ifid_valid_q, ifid_valid_d;
    logic [15:0] ifid_instr_q, ifid_instr_d;
    logic [15:0] ifid_pc_q,    ifid_pc_d;

    logic        dec_use_rs, dec_use_rt, dec_reg_write, dec_mem_read, dec_mem_write, dec_halt;
    logic [1:0]  dec_dest;
    logic [15:0] dec_imm;
    logic [1:0]  rs, rt;
    logic [15:0] opnd_a, opnd_b;

    logic        v_q, v_d, rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, h_q, h_d;
    logic [15:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [3:0]  op_q, op_d;
    logic [5:0]  fn_q, fn_d;
    logic [1:0]  dst_q, dst_d;

    id_decoder u_dec (
        .instr_i     (ifid_instr_q),
        .use_rs_o    (dec_use_rs),
        .use_rt_o    (dec_use_rt),
        .dest_o      (dec_dest),
        .reg_write_o (dec_reg_write),
        .mem_read_o  (dec_mem_read),
        .mem_write_o (dec_mem_write),
        .halt_o      (dec_halt),
        .imm_o       (dec_imm)
    );

    assign rs       = ifid_instr_q[11:10];
    assign rt       = ifid_instr_q[9:8];
    assign rf_read1 = rs;
    assign rf_read2 = rt;

    // Same-cycle write-back is not yet visible through the register file
    assign opnd_a = (wb_reg_write && wb_dest == rs) ? wb_data : rf_out1;
    assign opnd_b = (wb_reg_write && wb_dest == rt) ? wb_data : rf_out2;

    assign stall = ifid_valid_q & ex_valid & ex_mem_read &
                   ((dec_use_rs & (rs == ex_dest)) | (dec_use_rt & (rt == ex_dest)));

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        if (flush) begin
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            ifid_valid_d = if_valid;
            ifid_instr_d = if_instr;
            ifid_pc_d    = if_pc;
        end
    end

    always_comb begin
        pc_d  = ifid_pc_q;
        op_d  = ifid_instr_q[15:12];
        fn_d  = ifid_instr_q[5:0];
        a_d   = opnd_a;
        b_d   = opnd_b;
        imm_d = dec_imm;
        dst_d = dec_dest;
        v_d   = ifid_valid_q;
        rw_d  = dec_reg_write & ifid_valid_q;
        mr_d  = dec_mem_read  & ifid_valid_q;
        mw_d  = dec_mem_write & ifid_valid_q;
        h_d   = dec_halt      & ifid_valid_q;
        if (flush || stall) begin
            v_d  = 1'b0;
            rw_d = 1'b0;
            mr_d = 1'b0;
            mw_d = 1'b0;
            h_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= 16'h0000;
            ifid_pc_q    <= 16'h0000;
            v_q   <= 1'b0;
            rw_q  <= 1'b0;
            mr_q  <= 1'b0;
            mw_q  <= 1'b0;
            h_q   <= 1'b0;
            pc_q  <= 16'h0000;
            op_q  <= 4'h0;
            fn_q  <= 6'h00;
            a_q   <= 16'h0000;
            b_q   <= 16'h0000;
            imm_q <= 16'h0000;
            dst_q <= 2'd0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            v_q   <= v_d;
            rw_q  <= rw_d;
            mr_q  <= mr_d;
            mw_q  <= mw_d;
            h_q   <= h_d;
            pc_q  <= pc_d;
            op_q  <= op_d;
            fn_q  <= fn_d;
            a_q   <= a_d;
            b_q   <= b_d;
            imm_q <= imm_d;
            dst_q <= dst_d;
        end
    end

    assign idex_valid     = v_q;
    assign idex_pc        = pc_q;
    assign idex_opcode    = op_q;
    assign idex_func      = fn_q;
    assign idex_a         = a_q;
    assign idex_b         = b_q;
    assign idex_imm       = imm_q;
    assign idex_dest      = dst_q;
    assign idex_reg_write = rw_q;
    assign idex_mem_read  = mr_q;
    assign idex_mem_write = mw_q;
    assign idex_halt      = h_q;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
// Module      : tb_id_stage
// Description : Directed self-checking bench for the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset_n, if_valid, flush, wb_reg_write;
    logic [15:0] if_instr, if_pc, wb_data;
    logic [1:0]  wb_dest;
    logic        stall;
    logic [1:0]  rf_read1, rf_read2;
    logic [15:0] rf_out1, rf_out2;
    logic        ex_valid, ex_mem_read;
    logic [1:0]  ex_dest;
    logic        idex_valid, idex_reg_write, idex_mem_read, idex_mem_write, idex_halt;
    logic [15:0] idex_pc, idex_a, idex_b, idex_imm;
    logic [3:0]  idex_opcode;
    logic [5:0]  idex_func;
    logic [1:0]  idex_dest;

    logic [15:0] rf [4];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rf_out1     = rf[rf_read1];
    assign rf_out2     = rf[rf_read2];
    assign ex_valid    = idex_valid;
    assign ex_mem_read = idex_mem_read;
    assign ex_dest     = idex_dest;

    id_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .stall          (stall),
        .flush          (flush),
        .rf_read1       (rf_read1),
        .rf_read2       (rf_read2),
        .rf_out1        (rf_out1),
        .rf_out2        (rf_out2),
        .wb_reg_write   (wb_reg_write),
        .wb_dest        (wb_dest),
        .wb_data        (wb_data),
        .ex_valid       (ex_valid),
        .ex_mem_read    (ex_mem_read),
        .ex_dest        (ex_dest),
        .idex_valid     (idex_valid),
        .idex_pc        (idex_pc),
        .idex_opcode    (idex_opcode),
        .idex_func      (idex_func),
        .idex_a         (idex_a),
        .idex_b         (idex_b),
        .idex_imm       (idex_imm),
        .idex_dest      (idex_dest),
        .idex_reg_write (idex_reg_write),
        .idex_mem_read  (idex_mem_read),
        .idex_mem_write (idex_mem_write),
        .idex_halt      (idex_halt)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [15:0] instr, input logic [15:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    // Fetch one instruction, then a bubble: it sits in ID/EX afterwards
    task automatic issue(input logic [15:0] instr, input logic [15:0] pc);
        present(instr, pc);
        step();
        if_valid = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 16'h0000;
        reset_n = 1'b0; flush = 1'b0; wb_reg_write = 1'b0; wb_dest = 2'd0; wb_data = 16'h0;
        present(16'h4505, 16'h0001);
        step();
        step();
        check("rst_valid", {15'd0, idex_valid}, 16'h0);
        check("rst_rw",    {15'd0, idex_reg_write}, 16'h0);
        check("rst_imm",   idex_imm, 16'h0000);
        check("rst_pc",    idex_pc, 16'h0000);
        check("rst_stall", {15'd0, stall}, 16'h0);
        check("rst_rd1",   {14'd0, rf_read1}, 16'h0);

        reset_n = 1'b1;
        issue(16'h4105, 16'h0001);
        check("adi_valid", {15'd0, idex_valid}, 16'h1);
        check("adi_dest",  {14'd0, idex_dest}, 16'h1);
        check("adi_imm",   idex_imm, 16'h0005);
        check("adi_rw",    {15'd0, idex_reg_write}, 16'h1);
        check("adi_op",    {12'd0, idex_opcode}, 16'h4);
        check("adi_pc",    idex_pc, 16'h0001);
        check("adi_a",     idex_a, 16'h0000);

        issue(16'h41FF, 16'h0002);
        check("adi_neg_imm", idex_imm, 16'hFFFF);

        // Load-use: LWD $1 then ADD $2,$1,$1
        rf[1] = 16'h0055;
        present(16'h7100, 16'h0010);
        step();
        present(16'hF580, 16'h0011);
        check("lu_nostall0", {15'd0, stall}, 16'h0);
        step();
        check("lu_ld_mr",  {15'd0, idex_mem_read}, 16'h1);
        check("lu_stall",  {15'd0, stall}, 16'h1);
        step();
        check("lu_bubble", {15'd0, idex_valid}, 16'h0);
        check("lu_bub_rw", {15'd0, idex_reg_write}, 16'h0);
        check("lu_stall_end", {15'd0, stall}, 16'h0);
        if_valid = 1'b0;
        step();
        check("lu_add_valid", {15'd0, idex_valid}, 16'h1);
        check("lu_add_dest",  {14'd0, idex_dest}, 16'h2);
        check("lu_add_pc",    idex_pc, 16'h0011);
        check("lu_add_a",     idex_a, 16'h0055);

        // Write-back bypass over a stale register file
        rf[1] = 16'h0000;
        present(16'hF580, 16'h0020);
        step();
        if_valid = 1'b0;
        wb_reg_write = 1'b1; wb_dest = 2'd1; wb_data = 16'h1234;
        step();
        wb_reg_write = 1'b0;
        check("byp_a", idex_a, 16'h1234);
        check("byp_b", idex_b, 16'h1234);
        issue(16'hF580, 16'h0021);
        check("nobyp_a", idex_a, 16'h0000);

        // Flush while stalled
        present(16'h7100, 16'h0030);
        step();
        present(16'hF580, 16'h0031);
        step();
        check("fl_stall", {15'd0, stall}, 16'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_valid", {15'd0, idex_valid}, 16'h0);
        check("fl_mr",    {15'd0, idex_mem_read}, 16'h0);
        present(16'h63AB, 16'h0040);
        step();
        check("fl_ifid_empty", {15'd0, idex_valid}, 16'h0);
        if_valid = 1'b0;
        step();
        check("lhi_valid", {15'd0, idex_valid}, 16'h1);
        check("lhi_imm",   idex_imm, 16'hAB00);
        check("lhi_dest",  {14'd0, idex_dest}, 16'h3);

        issue(16'hA123, 16'h0050);
        check("jal_dest", {14'd0, idex_dest}, 16'h2);
        check("jal_imm",  idex_imm, 16'h0123);
        check("jal_rw",   {15'd0, idex_reg_write}, 16'h1);

        issue(16'hF01D, 16'h0051);
        check("hlt_halt", {15'd0, idex_halt}, 16'h1);
        check("hlt_rw",   {15'd0, idex_reg_write}, 16'h0);
        check("hlt_func", {10'd0, idex_func}, 16'h001D);

        issue(16'h51F0, 16'h0052);
        check("ori_imm", idex_imm, 16'h00F0);

        issue(16'h8180, 16'h0053);
        check("swd_mw",  {15'd0, idex_mem_write}, 16'h1);
        check("swd_rw",  {15'd0, idex_reg_write}, 16'h0);
        check("swd_imm", idex_imm, 16'hFF80);

        // Reset asserted mid-stream
        present(16'h4505, 16'h0060);
        step();
        reset_n = 1'b0;
        step();
        check("mrst_valid", {15'd0, idex_valid}, 16'h0);
        check("mrst_rd1",   {14'd0, rf_read1}, 16'h0);
        reset_n = 1'b1;
        if_valid = 1'b0;
        step();
        check("mrst_empty", {15'd0, idex_valid}, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 16-bit, four-register pipelined CPU. It holds the IF/ID pipeline register, decodes the latched instruction, and drives the register-file read addresses. It bypasses a same-cycle write-back into the operands, detects load-use hazards, and produces the ID/EX pipeline register consumed by the execute stage.

## Interface
- No parameters. Fixed widths: 16-bit data and PC, 2-bit register index.
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- if_valid  in  1  fetch presents a valid instruction.
- if_instr  in  16  fetched instruction.
- if_pc  in  16  PC+1 of the fetched instruction.
- stall  out  1  combinational; IF must hold its PC and re-present the same instruction.
- flush  in  1  branch/jump redirect from EX; kills IF/ID and ID/EX contents.
- rf_read1, rf_read2  out  2  register-file read addresses (rs, rt).
- rf_out1, rf_out2  in  16  asynchronous register-file read data.
- wb_reg_write  in  1  write-back enable this cycle.
- wb_dest  in  2  write-back register index.
- wb_data  in  16  write-back data.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_mem_read  in  1  EX instruction is LWD.
- ex_dest  in  2  EX destination register.
- idex_valid  out  1  ID/EX holds a valid instruction.
- idex_pc  out  16  latched PC+1.
- idex_opcode  out  4  latched opcode.
- idex_func  out  6  latched func field.
- idex_a  out  16  rs operand after bypass.
- idex_b  out  16  rt operand after bypass.
- idex_imm  out  16  extended immediate or jump target.
- idex_dest  out  2  destination register index.
- idex_reg_write, idex_mem_read, idex_mem_write, idex_halt  out  1  control bits.

## Operation
- Field layout: opcode [15:12], rs [11:10], rt [9:8], rd [7:6], func [5:0], imm [7:0], target [11:0].
- IF/ID register (valid, instr, pc):
  - reset_n low or flush: clear valid.
  - stall: hold all fields.
  - otherwise: load if_valid/if_instr/if_pc.
- Read addresses: rf_read1 = rs and rf_read2 = rt, always driven from IF/ID.
- WB bypass: if wb_reg_write and wb_dest equals rs (or rt), the corresponding operand takes wb_data, not rf_out.
- Register writes (reg_write=1, dest):
  - R-type (op 15), func 0–7: dest = rd.
  - JRL (op 15, func 26): dest = 2.
  - ADI, ORI, LHI, LWD (op 4–7): dest = rt.
  - JAL (op 10): dest = 2.
- Memory and halt controls: mem_read = LWD; mem_write = SWD (op 8); halt = op 15 with func 29.
- Source usage:
  - use_rs: R-type, op 4/5/7/8, and branches op 0–3.
  - use_rt: R-type func 0–3, SWD, and branches.
- Immediate extension:
  - ORI: zero-extend.
  - LHI: {imm, 8'h00}.
  - JMP/JAL: {4'b0, target}.
  - All other I-type: sign-extend imm.
- Load-use stall: stall = ifid_valid & ex_valid & ex_mem_read & ((use_rs & rs==ex_dest) | (use_rt & rt==ex_dest)).
- ID/EX register:
  - reset_n low or flush: clear valid and all control bits.
  - stall: insert a bubble (valid=0, control bits 0).
  - otherwise: load the decoded fields, with valid = ifid_valid.
- Priority: reset > flush > stall > normal. When flush coincides with stall, flush wins and stall is ignored.
- Invalid instructions (ifid_valid=0) never assert stall. They propagate with all control bits 0.

## Timing
- Reset values: every idex_* output is 0, IF/ID valid is 0, stall is 0, and rf_read1/rf_read2 are 0.
- Latency: an instruction accepted at edge N is in IF/ID during cycle N+1 and appears on idex_* after edge N+1. That is two edges, one per stage.
- Stall timing:
  - stall is combinational in the same cycle as the hazard.
  - A load-use pair costs exactly one bubble.
  - On the next cycle the load has left EX, and the dependent instruction proceeds.
- flush at edge N: both stages are invalid after N. The instruction presented by IF in the flush cycle is discarded.
- Reset asserted mid-stream clears state on the next edge regardless of stall or flush.

## Structure
- Shared package `cpu_defs`: opcode constants (ADI..JAL, RTYPE=15), func constants (ADD..HLT), and the immediate-kind enum (SEXT, ZEXT, LHI, JTGT).
- Sub-module `id_decoder`: purely combinational. Maps instr to use_rs, use_rt, dest, reg_write, mem_read, mem_write, halt, imm.
- `id_stage` owns the IF/ID and ID/EX registers, the bypass muxes, and the hazard logic.

## Test plan
- Reset: hold reset_n low for 2 cycles with if_valid=1 → all idex_* outputs 0 and stall=0.
- Immediate decode:
  - ADI $1,$0,5 (16'h4105) with R0=0 → two edges later idex_valid=1, idex_dest=1, idex_imm=16'h0005, idex_reg_write=1.
  - 16'h41FF → idex_imm=16'hFFFF.
- Load-use: LWD $1,0($0) (16'h7100) then ADD $2,$1,$1 (16'hF580), driving ex_* from idex_* → stall=1 for exactly one cycle, one bubble with idex_valid=0, then ADD issues with idex_dest=2.
- WB bypass: ADD reads $1 while wb_reg_write=1, wb_dest=1, wb_data=16'h1234, and the RF returns the stale value 0 → idex_a=idex_b=16'h1234.
- Flush during stall: assert flush in the load-use stall cycle → after the edge, idex_valid=0 and IF/ID is empty; the next if_instr is accepted normally.
- Control decode:
  - LHI $3,8'hAB (16'h63AB) → idex_imm=16'hAB00.
  - JAL 12'h123 (16'hA123) → idex_dest=2, idex_imm=16'h0123.
  - HLT (16'hF01D) → idex_halt=1.
